// File: rtl/b8_serial_add_ctrl_if.sv
// rtl/b8_serial_add_ctrl_if.sv - operand/result and external-adder signal bundle for b8_serial_add_ctrl
// Bit 0 of every vector is the MSB.
interface b8_serial_add_ctrl_if;
    logic       Start;
    logic [0:7] OpA;
    logic [0:7] OpB;
    logic       CarryIn;
    logic [0:3] AddA;
    logic [0:3] AddB;
    logic       AddCin;
    logic [0:3] AddSum;
    logic       AddCout;
    logic [0:7] Sum;
    logic       CarryOut;
    logic       Overflow;
    logic       Busy;
    logic       Done;

    modport slave (
        input  Start, OpA, OpB, CarryIn, AddSum, AddCout,
        output AddA, AddB, AddCin, Sum, CarryOut, Overflow, Busy, Done
    );

    modport master (
        output Start, OpA, OpB, CarryIn, AddSum, AddCout,
        input  AddA, AddB, AddCin, Sum, CarryOut, Overflow, Busy, Done
    );
endinterface

// File: rtl/b8_serial_add_ctrl.sv
// rtl/b8_serial_add_ctrl.sv - 8-bit add sequenced as two nibble passes through an external 4-bit adder
// Low nibble first (LOW), then high nibble with the saved carry (HIGH); Done pulses in DONE.
module b8_serial_add_ctrl (
    input  logic                  Clk,
    input  logic                  Reset,
    b8_serial_add_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state;
    state_t     nextState;

    logic [0:7] aReg;
    logic [0:7] bReg;
    logic       cinReg;
    logic       carryReg;
    logic [0:7] sumReg;
    logic       carryOutReg;
    logic       overflowReg;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = bus.Start ? LOW : IDLE;
            LOW:     nextState = HIGH;
            HIGH:    nextState = DONE;
            DONE:    nextState = bus.Start ? LOW : IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Operands are only sampled on the accepting edge, so input changes while busy are invisible.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            aReg        <= '0;
            bReg        <= '0;
            cinReg      <= 1'b0;
            carryReg    <= 1'b0;
            sumReg      <= '0;
            carryOutReg <= 1'b0;
            overflowReg <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.Start) begin
                        aReg   <= bus.OpA;
                        bReg   <= bus.OpB;
                        cinReg <= bus.CarryIn;
                    end
                end
                LOW: begin
                    sumReg[4:7] <= bus.AddSum;
                    carryReg    <= bus.AddCout;
                end
                HIGH: begin
                    sumReg[0:3] <= bus.AddSum;
                    carryOutReg <= bus.AddCout;
                    overflowReg <= (aReg[0] == bReg[0]) && (bus.AddSum[0] != aReg[0]);
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        bus.AddA   = '0;
        bus.AddB   = '0;
        bus.AddCin = 1'b0;
        bus.Busy   = 1'b0;
        bus.Done   = 1'b0;
        case (state)
            LOW: begin
                bus.AddA   = aReg[4:7];
                bus.AddB   = bReg[4:7];
                bus.AddCin = cinReg;
                bus.Busy   = 1'b1;
            end
            HIGH: begin
                bus.AddA   = aReg[0:3];
                bus.AddB   = bReg[0:3];
                bus.AddCin = carryReg;
                bus.Busy   = 1'b1;
            end
            DONE: begin
                bus.Done   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.Sum      = sumReg;
    assign bus.CarryOut = carryOutReg;
    assign bus.Overflow = overflowReg;

endmodule

// File: tb/tb_b8_serial_add_ctrl.sv
// tb/tb_b8_serial_add_ctrl.sv - directed bench with a cycle-age reference model for b8_serial_add_ctrl
module tb_b8_serial_add_ctrl;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   doneCnt = 0;

    b8_serial_add_ctrl_if bus ();

    b8_serial_add_ctrl dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // External 4-bit adder
    assign {bus.AddCout, bus.AddSum} = {1'b0, bus.AddA} + {1'b0, bus.AddB} + {4'b0000, bus.AddCin};

    // Reference model: age counts edges since the accepting edge (99 = no operation in flight).
    int         age = 99;
    logic [7:0] mA = '0;
    logic [7:0] mB = '0;
    logic       mC = 1'b0;
    logic [7:0] expSum = '0;
    logic       expCout = 1'b0;
    logic       expOvf = 1'b0;

    always @(posedge Clk or posedge Reset) begin : model
        logic       wasBusy;
        logic [8:0] full;
        logic [4:0] lo;
        if (Reset) begin
            age     = 99;
            mA      = '0;
            mB      = '0;
            mC      = 1'b0;
            expSum  = '0;
            expCout = 1'b0;
            expOvf  = 1'b0;
        end else begin
            wasBusy = (age == 0) || (age == 1);
            age = (age < 99) ? age + 1 : 99;
            if (bus.Start && !wasBusy) begin
                mA  = bus.OpA;
                mB  = bus.OpB;
                mC  = bus.CarryIn;
                age = 0;
            end
            full = {1'b0, mA} + {1'b0, mB} + {8'd0, mC};
            lo   = {1'b0, mA[3:0]} + {1'b0, mB[3:0]} + {4'd0, mC};
            if (age == 1) expSum[3:0] = lo[3:0];
            if (age == 2) begin
                expSum  = full[7:0];
                expCout = full[8];
                expOvf  = (mA[7] == mB[7]) && (full[7] != mA[7]);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin : compare
        logic [3:0] eA;
        logic [3:0] eB;
        logic       eCin;
        logic [4:0] lo;
        lo   = {1'b0, mA[3:0]} + {1'b0, mB[3:0]} + {4'd0, mC};
        eA   = '0;
        eB   = '0;
        eCin = 1'b0;
        if (age == 0) begin
            eA = mA[3:0]; eB = mB[3:0]; eCin = mC;
        end else if (age == 1) begin
            eA = mA[7:4]; eB = mB[7:4]; eCin = lo[4];
        end
        check("Sum",      32'(bus.Sum),      32'(expSum));
        check("CarryOut", 32'(bus.CarryOut), 32'(expCout));
        check("Overflow", 32'(bus.Overflow), 32'(expOvf));
        check("Busy",     32'(bus.Busy),     32'((age == 0) || (age == 1)));
        check("Done",     32'(bus.Done),     32'(age == 2));
        check("AddA",     32'(bus.AddA),     32'(eA));
        check("AddB",     32'(bus.AddB),     32'(eB));
        check("AddCin",   32'(bus.AddCin),   32'(eCin));
        if (bus.Done === 1'b1) doneCnt++;
    end

    // Starts a one-cycle-Start operation and returns at the DONE-cycle negedge after checking literals.
    task automatic runOp(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [7:0] eS, input logic eC, input logic eO, input string tag);
        @(negedge Clk);
        bus.Start = 1'b1; bus.OpA = a; bus.OpB = b; bus.CarryIn = c;
        @(negedge Clk);
        bus.Start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check({tag, "_done"}, 32'(bus.Done),     32'd1);
        check({tag, "_sum"},  32'(bus.Sum),      32'(eS));
        check({tag, "_cout"}, 32'(bus.CarryOut), 32'(eC));
        check({tag, "_ovf"},  32'(bus.Overflow), 32'(eO));
    endtask

    initial begin : stim
        int snap;
        bus.Start = 1'b0; bus.OpA = '0; bus.OpB = '0; bus.CarryIn = 1'b0;
        #1 Reset = 1'b1;
        repeat (2) @(negedge Clk);
        check("rst_sum",  32'(bus.Sum),  32'h00);
        check("rst_busy", 32'(bus.Busy), 32'd0);
        check("rst_done", 32'(bus.Done), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);

        // 0x0F + 0x01: low nibble carries out
        bus.Start = 1'b1; bus.OpA = 8'h0F; bus.OpB = 8'h01; bus.CarryIn = 1'b0;
        @(negedge Clk);
        bus.Start = 1'b0;
        check("low_cout", 32'(bus.AddCout), 32'd1);
        @(negedge Clk);
        @(negedge Clk);
        check("r21_done", 32'(bus.Done),     32'd1);
        check("r21_sum",  32'(bus.Sum),      32'h10);
        check("r21_cout", 32'(bus.CarryOut), 32'd0);
        check("r21_ovf",  32'(bus.Overflow), 32'd0);
        @(negedge Clk);
        check("r21_pulse", 32'(bus.Done), 32'd0);

        runOp(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "r22a");
        runOp(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, "r22b");
        repeat (2) @(negedge Clk);

        // Start re-pulsed while busy with different operands is ignored
        #1 snap = doneCnt;
        @(negedge Clk);
        bus.Start = 1'b1; bus.OpA = 8'h12; bus.OpB = 8'h34; bus.CarryIn = 1'b0;
        @(negedge Clk);
        bus.OpA = 8'hAA;
        @(negedge Clk);
        bus.Start = 1'b0; bus.OpA = 8'h55;
        @(negedge Clk);
        check("r23_sum", 32'(bus.Sum), 32'h46);
        repeat (3) @(negedge Clk);
        #1 check("r23_ndone", 32'(doneCnt - snap), 32'd1);

        // Start held for 9 edges: three back-to-back operations
        snap = doneCnt;
        @(negedge Clk);
        bus.Start = 1'b1; bus.OpA = 8'h01; bus.OpB = 8'h01; bus.CarryIn = 1'b0;
        repeat (9) begin
            @(negedge Clk);
            if (bus.Done === 1'b1) check("r24_sum", 32'(bus.Sum), 32'h02);
        end
        bus.Start = 1'b0;
        repeat (3) @(negedge Clk);
        #1 check("r24_ndone", 32'(doneCnt - snap), 32'd3);

        // Asynchronous reset in the middle of the HIGH cycle
        snap = doneCnt;
        @(negedge Clk);
        bus.Start = 1'b1; bus.OpA = 8'hFF; bus.OpB = 8'hFF; bus.CarryIn = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;
        @(negedge Clk);
        check("r25_inhigh", 32'(bus.Sum), 32'h0F);
        #2 Reset = 1'b1;
        #1;
        check("r25_busy", 32'(bus.Busy),     32'd0);
        check("r25_sum",  32'(bus.Sum),      32'h00);
        check("r25_adda", 32'(bus.AddA),     32'h0);
        check("r25_cin",  32'(bus.AddCin),   32'd0);
        check("r25_cout", 32'(bus.CarryOut), 32'd0);
        check("r25_done", 32'(bus.Done),     32'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        #1 check("r25_ndone", 32'(doneCnt - snap), 32'd0);
        runOp(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "r25b");
        repeat (2) @(negedge Clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
